// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine (SHL/SHR/SHRA/ROL/ROR), STEP bits per clock, start/busy/done.
// Optional abort input when SEQ_SHIFT_ABORT_EN is defined.
module seq_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] amt_in,
`ifdef SEQ_SHIFT_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = AMT_W + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [2:0] ModeShl  = 3'd0;
  localparam logic [2:0] ModeShr  = 3'd1;
  localparam logic [2:0] ModeShra = 3'd2;
  localparam logic [2:0] ModeRol  = 3'd3;
  localparam logic [2:0] ModeRor  = 3'd4;

  logic [1:0]       r_state, w_state_d;
  logic [WIDTH-1:0] r_work, w_work_d;
  logic [AMT_W-1:0] r_count, w_count_d;
  logic [2:0]       r_mode, w_mode_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_err, w_err_d;

  logic [CW-1:0]    w_s, w_rs;
  logic [WIDTH-1:0] w_shifted;
  logic             w_abort;
  logic             w_unused_amt_hi;

  assign w_unused_amt_hi = ^amt_in[WIDTH-1:AMT_W];

`ifdef SEQ_SHIFT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Per-cycle step is min(STEP, count); count is never 0 while shifting.
  always_comb begin
    w_s  = ({1'b0, r_count} < CW'(STEP)) ? {1'b0, r_count} : CW'(STEP);
    w_rs = CW'(WIDTH) - w_s;
    case (r_mode)
      ModeShl:  w_shifted = r_work << w_s;
      ModeShr:  w_shifted = r_work >> w_s;
      ModeShra: w_shifted = $signed(r_work) >>> w_s;
      ModeRol:  w_shifted = (r_work << w_s) | (r_work >> w_rs);
      ModeRor:  w_shifted = (r_work >> w_s) | (r_work << w_rs);
      default:  w_shifted = r_work;
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_work_d   = r_work;
    w_count_d  = r_count;
    w_mode_d   = r_mode;
    w_result_d = r_result;
    w_busy_d   = 1'b0;
    w_done_d   = 1'b0;
    w_err_d    = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_work_d  = a_in;
          w_count_d = amt_in[AMT_W-1:0];
          w_mode_d  = mode;
          if (mode > ModeRor) begin
            w_state_d  = StDone;
            w_result_d = a_in;
            w_done_d   = 1'b1;
            w_err_d    = 1'b1;
          end else if (amt_in[AMT_W-1:0] == '0) begin
            w_state_d  = StDone;
            w_result_d = a_in;
            w_done_d   = 1'b1;
          end else begin
            w_state_d = StShift;
            w_busy_d  = 1'b1;
          end
        end
      end
      StShift: begin
        if (w_abort) begin
          w_state_d = StIdle;
        end else begin
          w_work_d  = w_shifted;
          w_count_d = r_count - w_s[AMT_W-1:0];
          if (w_count_d == '0) begin
            w_state_d  = StDone;
            w_result_d = w_shifted;
            w_done_d   = 1'b1;
          end else begin
            w_busy_d = 1'b1;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= StIdle;
      r_work   <= '0;
      r_count  <= '0;
      r_mode   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_work   <= w_work_d;
      r_count  <= w_count_d;
      r_mode   <= w_mode_d;
      r_result <= w_result_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_err    <= w_err_d;
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: STEP=1 and STEP=4 instances, vector table plus corner sequences.
// Abort sequence is built only when SEQ_SHIFT_ABORT_EN is defined.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start1, start4;
  logic [2:0]  mode;
  logic [31:0] a_in, amt_in;
  logic        abort1;
  logic [31:0] result1, result4;
  logic        busy1, busy4, done1, done4, err1, err4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u1 (
    .clk    (clk),
    .clr    (clr),
    .start  (start1),
    .mode   (mode),
    .a_in   (a_in),
    .amt_in (amt_in),
`ifdef SEQ_SHIFT_ABORT_EN
    .abort  (abort1),
`endif
    .result (result1),
    .busy   (busy1),
    .done   (done1),
    .err    (err1)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(4)) u4 (
    .clk    (clk),
    .clr    (clr),
    .start  (start4),
    .mode   (mode),
    .a_in   (a_in),
    .amt_in (amt_in),
`ifdef SEQ_SHIFT_ABORT_EN
    .abort  (1'b0),
`endif
    .result (result4),
    .busy   (busy4),
    .done   (done4),
    .err    (err4)
  );

  typedef struct {
    string       name;
    bit          use4;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] amt;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_k;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one operation; k counts edges after E0 until done is seen.
  task automatic run_op(input vec_t v);
    int          k;
    logic [31:0] prev;
    @(negedge clk);
    prev = v.use4 ? result4 : result1;
    mode = v.mode; a_in = v.a; amt_in = v.amt;
    if (v.use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    mode = 3'b111; a_in = 32'hA5A5_A5A5; amt_in = 32'h0000_0003;
    if (v.exp_k > 0) begin
      chk({v.name, " busy@E0"}, v.use4 ? busy4 : busy1, 1);
      chk({v.name, " hold@E0"}, v.use4 ? result4 : result1, prev);
    end
    k = 0;
    while (!(v.use4 ? done4 : done1) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({v.name, " k"}, k, v.exp_k);
    chk({v.name, " result"}, v.use4 ? result4 : result1, v.exp_res);
    chk({v.name, " err"}, v.use4 ? err4 : err1, v.exp_err);
    chk({v.name, " busy@done"}, v.use4 ? busy4 : busy1, 0);
    @(posedge clk); #1;
    chk({v.name, " done 1cyc"}, v.use4 ? {err4, done4} : {err1, done1}, 0);
  endtask

  task automatic no_done(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done1) seen = 1'b1;
    end
    chk(name, seen, 0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    clr = 1'b1; start1 = 1'b0; start4 = 1'b0; abort1 = 1'b0;
    mode = '0; a_in = '0; amt_in = '0;

    vecs.push_back('{"shl",       0, 3'd0, 32'hF000_0096, 32'd4,  32'h0000_0960, 1'b0, 4});
    vecs.push_back('{"shra",      0, 3'd2, 32'hF000_0096, 32'd4,  32'hFF00_0009, 1'b0, 4});
    vecs.push_back('{"shr",       0, 3'd1, 32'hF000_0096, 32'd4,  32'h0F00_0009, 1'b0, 4});
    vecs.push_back('{"ror_wrap",  0, 3'd4, 32'h0000_0014, 32'h24, 32'h4000_0001, 1'b0, 4});
    vecs.push_back('{"rol",       0, 3'd3, 32'hF000_0096, 32'd4,  32'h0000_096F, 1'b0, 4});
    vecs.push_back('{"rol_n0",    0, 3'd3, 32'h1234_5678, 32'd0,  32'h1234_5678, 1'b0, 0});
    vecs.push_back('{"bad_mode",  0, 3'd6, 32'hDEAD_BEEF, 32'd5,  32'hDEAD_BEEF, 1'b1, 0});
    vecs.push_back('{"shl_amt36", 0, 3'd0, 32'h0000_0001, 32'd36, 32'h0000_0010, 1'b0, 4});
    vecs.push_back('{"shra_31",   0, 3'd2, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31});
    vecs.push_back('{"shr_31",    0, 3'd1, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 31});
    vecs.push_back('{"rol_1",     0, 3'd3, 32'h8000_0001, 32'd1,  32'h0000_0003, 1'b0, 1});
    vecs.push_back('{"s4_shl7",   1, 3'd0, 32'h0000_0001, 32'd7,  32'h0000_0080, 1'b0, 2});
    vecs.push_back('{"s4_rol6",   1, 3'd3, 32'hF000_0096, 32'd6,  32'h0000_25BC, 1'b0, 2});
    vecs.push_back('{"s4_ror4",   1, 3'd4, 32'h0000_0014, 32'd4,  32'h4000_0001, 1'b0, 1});

    #12;
    chk("reset out", {result1, 29'd0, busy1, done1, err1}, 64'd0);
    @(negedge clk); clr = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v);
    end

    // STEP=4, start held high: ignored while busy/done, re-accepted at first IDLE edge.
    @(negedge clk);
    mode = 3'd0; a_in = 32'h1; amt_in = 32'd7; start4 = 1'b1;
    @(posedge clk); #1;                 // E0
    @(posedge clk); #1;                 // E1
    chk("hold busyE1", {busy4, done4}, 2'b10);
    a_in = 32'h2; amt_in = 32'd4;
    @(posedge clk); #1;                 // E2
    chk("hold doneE2", {busy4, done4}, 2'b01);
    chk("hold resE2", result4, 32'h80);
    @(posedge clk); #1;                 // E3: DONE->IDLE, start ignored
    chk("hold idleE3", {busy4, done4}, 2'b00);
    @(posedge clk); #1;                 // E4: second op accepted
    chk("hold busyE4", busy4, 1);
    start4 = 1'b0;
    @(posedge clk); #1;                 // E5
    chk("hold done2", done4, 1);
    chk("hold res2", result4, 32'h20);

    // Asynchronous clr mid-shift.
    @(negedge clk);
    mode = 3'd0; a_in = 32'h1; amt_in = 32'd20; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr outs", {result1, 29'd0, busy1, done1, err1}, 64'd0);
    @(negedge clk); @(negedge clk); clr = 1'b0;
    no_done("clr no done", 25);

`ifdef SEQ_SHIFT_ABORT_EN
    v = '{"pre_abort", 0, 3'd1, 32'h0000_0F00, 32'd8, 32'h0000_000F, 1'b0, 8};
    run_op(v);
    @(negedge clk);
    mode = 3'd0; a_in = 32'h1; amt_in = 32'd20; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;  // E0
    @(posedge clk); #1; abort1 = 1'b1;  // E1
    @(posedge clk); #1; abort1 = 1'b0;  // E2 samples abort
    chk("abort busy", {busy1, done1, err1}, 3'b000);
    chk("abort res", result1, 32'h0000_000F);
    no_done("abort no done", 25);
    v = '{"post_abort", 0, 3'd0, 32'h0000_0003, 32'd2, 32'h0000_000C, 1'b0, 2};
    run_op(v);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
